// File: rtl/conv2_mac_sequencer.sv
// Conv2 MAC sequencer: sweeps the weight memory once per start, accumulates two-tap
// products over all input channels and emits one rescaled, saturated result per output filter.
module conv2_mac_sequencer #(
  parameter int N_OUT     = 10,
  parameter int N_IN      = 20,
  parameter int FRAC_BITS = 12,
  parameter int ACC_W     = 40,
  parameter int RELU_EN   = 1,
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic [3:0]               output_filter,
  output logic [4:0]               input_filter,
  input  logic signed [COEF_W-1:0] w0,
  input  logic signed [COEF_W-1:0] w1,
  input  logic signed [DATA_W-1:0] x0,
  input  logic signed [DATA_W-1:0] x1,
  output logic                     busy,
  output logic                     out_valid,
  output logic [3:0]               out_filter,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     done
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int STAGES = 2;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t state, state_nxt;

  logic [3:0] f_cnt;
  logic [4:0] c_cnt;
  logic [1:0] drain_cnt;
  logic       row_end;
  logic       last_k;

  logic                     vld_p0;
  logic                     last_p0;
  logic [3:0]               fil_p0;
  logic signed [PROD_W-1:0] prod0_p0;
  logic signed [PROD_W-1:0] prod1_p0;

  logic signed [ACC_W-1:0] acc_p1;
  logic signed [ACC_W-1:0] acc_nxt;

  function automatic logic signed [DATA_W-1:0] sat_relu(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0]  s;
    logic signed [DATA_W-1:0] r;
    s = v >>> FRAC_BITS;
    if (s > SAT_MAX)      r = SAT_MAX[DATA_W-1:0];
    else if (s < SAT_MIN) r = SAT_MIN[DATA_W-1:0];
    else                  r = s[DATA_W-1:0];
    if ((RELU_EN != 0) && r[DATA_W-1]) r = '0;
    return r;
  endfunction

  assign row_end       = (c_cnt == 5'(N_IN - 1));
  assign last_k        = row_end && (f_cnt == 4'(N_OUT - 1));
  assign output_filter = f_cnt;
  assign input_filter  = c_cnt;
  assign busy          = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_k) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt == 2'(STAGES - 1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Address generation: channel index is the fast counter, filter advances on its wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      f_cnt     <= '0;
      c_cnt     <= '0;
      drain_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          drain_cnt <= '0;
          if (row_end) begin
            c_cnt <= '0;
            f_cnt <= last_k ? 4'd0 : f_cnt + 4'd1;
          end else begin
            c_cnt <= c_cnt + 5'd1;
          end
        end
        DRAIN: drain_cnt <= drain_cnt + 2'd1;
        default: begin
          f_cnt     <= '0;
          c_cnt     <= '0;
          drain_cnt <= '0;
        end
      endcase
    end
  end

  // Stage p0: products of the taps returned for the address issued this cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0   <= 1'b0;
      last_p0  <= 1'b0;
      fil_p0   <= '0;
      prod0_p0 <= '0;
      prod1_p0 <= '0;
    end else begin
      vld_p0   <= (state == RUN);
      last_p0  <= row_end;
      fil_p0   <= f_cnt;
      prod0_p0 <= PROD_W'(w0) * PROD_W'(x0);
      prod1_p0 <= PROD_W'(w1) * PROD_W'(x1);
    end
  end

  assign acc_nxt = acc_p1 + ACC_W'(prod0_p0) + ACC_W'(prod1_p0);

  // Stage p1: accumulate; on the last channel of a filter emit the result and restart the sum
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_p1     <= '0;
      out_valid  <= 1'b0;
      done       <= 1'b0;
      out_filter <= '0;
      out_data   <= '0;
    end else begin
      out_valid <= 1'b0;
      done      <= 1'b0;
      if (vld_p0) begin
        if (last_p0) begin
          out_data   <= sat_relu(acc_nxt);
          out_filter <= fil_p0;
          out_valid  <= 1'b1;
          done       <= (fil_p0 == 4'(N_OUT - 1));
          acc_p1     <= '0;
        end else begin
          acc_p1 <= acc_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv2_mac_sequencer.sv
// Bench for conv2_mac_sequencer: ReLU and non-ReLU instances run in lockstep, each fed
// from its own memory lookup, results compared against a per-filter dot-product model.
module tb_conv2_mac_sequencer;

  localparam int OBS = 215;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  always #5 clk = ~clk;

  logic signed [15:0] wm0 [0:9][0:19];
  logic signed [15:0] wm1 [0:9][0:19];
  logic signed [15:0] xb0 [0:19];
  logic signed [15:0] xb1 [0:19];

  logic [3:0] r_of, n_of, r_ofil, n_ofil;
  logic [4:0] r_if, n_if;
  logic signed [15:0] r_w0, r_w1, r_x0, r_x1, n_w0, n_w1, n_x0, n_x1, r_data, n_data;
  logic r_busy, r_valid, r_done, n_busy, n_valid, n_done;

  assign r_w0 = wm0[r_of][r_if];
  assign r_w1 = wm1[r_of][r_if];
  assign r_x0 = xb0[r_if];
  assign r_x1 = xb1[r_if];
  assign n_w0 = wm0[n_of][n_if];
  assign n_w1 = wm1[n_of][n_if];
  assign n_x0 = xb0[n_if];
  assign n_x1 = xb1[n_if];

  conv2_mac_sequencer #(.RELU_EN(1)) dut_r (
    .clk(clk), .rst(rst), .start(start),
    .output_filter(r_of), .input_filter(r_if),
    .w0(r_w0), .w1(r_w1), .x0(r_x0), .x1(r_x1),
    .busy(r_busy), .out_valid(r_valid), .out_filter(r_ofil), .out_data(r_data), .done(r_done)
  );

  conv2_mac_sequencer #(.RELU_EN(0)) dut_n (
    .clk(clk), .rst(rst), .start(start),
    .output_filter(n_of), .input_filter(n_if),
    .w0(n_w0), .w1(n_w1), .x0(n_x0), .x1(n_x1),
    .busy(n_busy), .out_valid(n_valid), .out_filter(n_ofil), .out_data(n_data), .done(n_done)
  );

  int n_checks = 0;
  int n_pass = 0;

  // Per-cycle observations of the ReLU instance, indexed by RUN-relative cycle
  logic       o_busy [OBS];
  logic       o_valid [OBS];
  logic [3:0] o_of [OBS];
  logic [4:0] o_if [OBS];
  logic [3:0] o_fil [OBS];
  int         o_data [OBS];

  int rs_cnt, rd_cnt, rd_cyc, ns_cnt, nd_cnt, nd_cyc;
  int rs_cyc [16];
  int rs_fil [16];
  int rs_dat [16];
  int ns_fil [16];
  int ns_dat [16];

  function automatic int model(input int f, input bit relu);
    longint s = 0;
    for (int c = 0; c < 20; c++)
      s += longint'(wm0[f][c]) * longint'(xb0[c]) + longint'(wm1[f][c]) * longint'(xb1[c]);
    s = s >>> 12;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    if (relu && s < 0) s = 0;
    return int'(s);
  endfunction

  task automatic fill_const(input int w, input int x);
    for (int f = 0; f < 10; f++)
      for (int c = 0; c < 20; c++) begin
        wm0[f][c] = 16'(w);
        wm1[f][c] = 16'(w);
      end
    for (int c = 0; c < 20; c++) begin
      xb0[c] = 16'(x);
      xb1[c] = 16'(x);
    end
  endtask

  task automatic fill_rand(input int m);
    int t;
    for (int f = 0; f < 10; f++)
      for (int c = 0; c < 20; c++) begin
        t = int'($urandom_range(0, 2 * m)) - m; wm0[f][c] = 16'(t);
        t = int'($urandom_range(0, 2 * m)) - m; wm1[f][c] = 16'(t);
      end
    for (int c = 0; c < 20; c++) begin
      t = int'($urandom_range(0, 2 * m)) - m; xb0[c] = 16'(t);
      t = int'($urandom_range(0, 2 * m)) - m; xb1[c] = 16'(t);
    end
  endtask

  // Pulses start, then records a fixed window of cycles; optional extra start / reset pulses
  task automatic run_collect(input int extra_start, input int rst_at);
    rs_cnt = 0; rd_cnt = 0; rd_cyc = -1; ns_cnt = 0; nd_cnt = 0; nd_cyc = -1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int r = 0; r < OBS; r++) begin
      o_busy[r] = r_busy; o_valid[r] = r_valid; o_of[r] = r_of; o_if[r] = r_if;
      o_fil[r] = r_ofil; o_data[r] = int'(r_data);
      if (r_valid) begin
        if (rs_cnt < 16) begin
          rs_cyc[rs_cnt] = r; rs_fil[rs_cnt] = int'(r_ofil); rs_dat[rs_cnt] = int'(r_data);
        end
        rs_cnt++;
      end
      if (r_done) begin rd_cnt++; rd_cyc = r; end
      if (n_valid) begin
        if (ns_cnt < 16) begin ns_fil[ns_cnt] = int'(n_ofil); ns_dat[ns_cnt] = int'(n_data); end
        ns_cnt++;
      end
      if (n_done) begin nd_cnt++; nd_cyc = r; end
      start = (r == extra_start);
      rst   = (r == rst_at);
      @(negedge clk);
    end
    start = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) begin @(negedge clk); start = ~start; end
    @(negedge clk);
    start = 1'b0;
    n_checks++; if (r_busy !== 1'b0) $display("FAIL reset_busy got %b want 0", r_busy); else n_pass++;
    n_checks++; if ({r_valid, r_done} !== 2'b00) $display("FAIL reset_strobes got %b want 00", {r_valid, r_done}); else n_pass++;
    n_checks++; if ({r_of, r_if} !== 9'd0) $display("FAIL reset_addr got %h want 0", {r_of, r_if}); else n_pass++;
    n_checks++; if ({r_ofil, r_data} !== 20'd0) $display("FAIL reset_outputs got %h want 0", {r_ofil, r_data}); else n_pass++;
    n_checks++; if ({n_busy, n_valid, n_done, n_of, n_if, n_ofil, n_data} !== 32'd0)
      $display("FAIL reset_norelu got %h want 0", {n_busy, n_valid, n_done, n_of, n_if, n_ofil, n_data}); else n_pass++;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (r_busy !== 1'b0) $display("FAIL idle_busy got %b want 0", r_busy); else n_pass++;
  endtask

  task automatic test_unity();
    fill_const(4096, 1);
    run_collect(-1, -1);
    n_checks++; if (rs_cnt !== 10) $display("FAIL unity_count got %0d want 10", rs_cnt); else n_pass++;
    n_checks++; if (rd_cnt !== 1 || rd_cyc !== rs_cyc[9]) $display("FAIL unity_done got %0d@%0d want 1@%0d", rd_cnt, rd_cyc, rs_cyc[9]); else n_pass++;
    for (int i = 0; i < 10; i++) begin
      n_checks++; if (rs_fil[i] !== i) $display("FAIL unity_filter[%0d] got %0d want %0d", i, rs_fil[i], i); else n_pass++;
      n_checks++; if (rs_dat[i] !== 40) $display("FAIL unity_data[%0d] got %0d want 40", i, rs_dat[i]); else n_pass++;
    end
  endtask

  task automatic test_timing();
    int addr_err, busy_err;
    fill_rand(2000);
    run_collect(-1, -1);
    addr_err = 0; busy_err = 0;
    for (int r = 0; r < OBS; r++) begin
      if (r < 200) begin
        if (o_of[r] !== 4'(r / 20) || o_if[r] !== 5'(r % 20)) addr_err++;
      end else if (o_of[r] !== 4'd0 || o_if[r] !== 5'd0) addr_err++;
      if (o_busy[r] !== (r < 202)) busy_err++;
    end
    n_checks++; if (addr_err !== 0) $display("FAIL timing_addr_sweep got %0d bad cycles want 0", addr_err); else n_pass++;
    n_checks++; if (busy_err !== 0) $display("FAIL timing_busy got %0d bad cycles want 0", busy_err); else n_pass++;
    n_checks++; if (rs_cnt !== 10) $display("FAIL timing_count got %0d want 10", rs_cnt); else n_pass++;
    n_checks++; if (rd_cnt !== 1 || rd_cyc !== 201) $display("FAIL timing_done got %0d@%0d want 1@201", rd_cnt, rd_cyc); else n_pass++;
    n_checks++; if (o_data[30] !== rs_dat[0] || o_fil[30] !== 4'd0) $display("FAIL timing_hold got %0d want %0d", o_data[30], rs_dat[0]); else n_pass++;
    n_checks++; if (o_valid[22] !== 1'b0) $display("FAIL timing_strobe_width got %b want 0", o_valid[22]); else n_pass++;
    for (int i = 0; i < 10; i++) begin
      n_checks++; if (rs_cyc[i] !== 21 + 20 * i) $display("FAIL timing_cycle[%0d] got %0d want %0d", i, rs_cyc[i], 21 + 20 * i); else n_pass++;
      n_checks++; if (rs_dat[i] !== model(i, 1)) $display("FAIL rand_relu[%0d] got %0d want %0d", i, rs_dat[i], model(i, 1)); else n_pass++;
      n_checks++; if (ns_dat[i] !== model(i, 0)) $display("FAIL rand_plain[%0d] got %0d want %0d", i, ns_dat[i], model(i, 0)); else n_pass++;
    end
  endtask

  task automatic test_random_full();
    fill_rand(32768);
    run_collect(-1, -1);
    n_checks++; if (ns_cnt !== 10 || nd_cnt !== 1 || nd_cyc !== 201) $display("FAIL full_count got %0d/%0d@%0d want 10/1@201", ns_cnt, nd_cnt, nd_cyc); else n_pass++;
    for (int i = 0; i < 10; i++) begin
      n_checks++; if (ns_dat[i] !== model(i, 0) || ns_fil[i] !== i) $display("FAIL full_plain[%0d] got %0d want %0d", i, ns_dat[i], model(i, 0)); else n_pass++;
      n_checks++; if (rs_dat[i] !== model(i, 1)) $display("FAIL full_relu[%0d] got %0d want %0d", i, rs_dat[i], model(i, 1)); else n_pass++;
    end
  endtask

  task automatic test_saturation();
    fill_const(32767, 32767);
    run_collect(-1, -1);
    for (int i = 0; i < 10; i++) begin
      n_checks++; if (rs_dat[i] !== 32767 || ns_dat[i] !== 32767) $display("FAIL sat_pos[%0d] got %0d/%0d want 32767", i, rs_dat[i], ns_dat[i]); else n_pass++;
    end
    fill_const(32767, -32768);
    run_collect(-1, -1);
    for (int i = 0; i < 10; i++) begin
      n_checks++; if (ns_dat[i] !== -32768) $display("FAIL sat_neg[%0d] got %0d want -32768", i, ns_dat[i]); else n_pass++;
      n_checks++; if (rs_dat[i] !== 0) $display("FAIL sat_neg_relu[%0d] got %0d want 0", i, rs_dat[i]); else n_pass++;
    end
  endtask

  task automatic test_floor_shift();
    fill_rand(1000);
    fill_const(0, 0);
    wm0[3][7] = -16'sd1;
    xb0[7] = 16'sd1;
    run_collect(-1, -1);
    n_checks++; if (ns_cnt !== 10) $display("FAIL floor_count got %0d want 10", ns_cnt); else n_pass++;
    for (int i = 0; i < 10; i++) begin
      n_checks++; if (ns_dat[i] !== ((i == 3) ? -1 : 0)) $display("FAIL floor_plain[%0d] got %0d want %0d", i, ns_dat[i], (i == 3) ? -1 : 0); else n_pass++;
      n_checks++; if (rs_dat[i] !== 0) $display("FAIL floor_relu[%0d] got %0d want 0", i, rs_dat[i]); else n_pass++;
    end
  endtask

  task automatic test_start_while_busy();
    fill_rand(3000);
    run_collect(50, -1);
    n_checks++; if (rs_cnt !== 10 || ns_cnt !== 10) $display("FAIL busy_start_count got %0d/%0d want 10", rs_cnt, ns_cnt); else n_pass++;
    n_checks++; if (rd_cnt !== 1 || rd_cyc !== 201) $display("FAIL busy_start_done got %0d@%0d want 1@201", rd_cnt, rd_cyc); else n_pass++;
    n_checks++; if (o_busy[205] !== 1'b0) $display("FAIL busy_start_idle got %b want 0", o_busy[205]); else n_pass++;
    for (int i = 0; i < 10; i++) begin
      n_checks++; if (rs_dat[i] !== model(i, 1) || ns_dat[i] !== model(i, 0))
        $display("FAIL busy_start_data[%0d] got %0d/%0d want %0d/%0d", i, rs_dat[i], ns_dat[i], model(i, 1), model(i, 0)); else n_pass++;
    end
  endtask

  task automatic test_reset_mid_op();
    int late_busy;
    fill_const(4096, 1);
    run_collect(-1, 60);
    late_busy = 0;
    for (int r = 61; r < OBS; r++) if (o_busy[r] !== 1'b0) late_busy++;
    n_checks++; if (rs_cnt !== 2 || ns_cnt !== 2) $display("FAIL midrst_count got %0d/%0d want 2", rs_cnt, ns_cnt); else n_pass++;
    n_checks++; if (rd_cnt !== 0 || nd_cnt !== 0) $display("FAIL midrst_done got %0d/%0d want 0", rd_cnt, nd_cnt); else n_pass++;
    n_checks++; if ({o_valid[61], o_of[61], o_if[61], o_fil[61]} !== 14'd0) $display("FAIL midrst_ctrl got %h want 0", {o_valid[61], o_of[61], o_if[61], o_fil[61]}); else n_pass++;
    n_checks++; if (o_data[61] !== 0) $display("FAIL midrst_data got %0d want 0", o_data[61]); else n_pass++;
    n_checks++; if (late_busy !== 0) $display("FAIL midrst_busy got %0d busy cycles want 0", late_busy); else n_pass++;
  endtask

  initial begin
    fill_const(0, 0);
    test_reset();
    test_unity();
    test_timing();
    test_random_full();
    test_saturation();
    test_floor_shift();
    test_start_while_busy();
    test_reset_mid_op();
    test_unity();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
